// File: rtl/cnt_month_year.sv
// BCD month/year counter driven by the day-counter carry, with a
// set mode for adjusting month and year-of-century.
module cnt_month_year #(
  parameter logic [7:0] CENTURY = 8'h20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       CARRY_in,
  input  logic       SET_MODE,
  input  logic       SET_SEL,
  input  logic       SET_INC,
  output logic [7:0] month,
  output logic [7:0] YEAR,
  output logic [7:0] CENTURY_out,
  output logic       is_leap,
  output logic [7:0] DAYS_IN_MONTH,
  output logic       CARRY_out
);

  logic       count_ev;
  logic       month_ok;
  logic       month_wrap;
  logic       year_wrap;
  logic [7:0] month_nx;
  logic [7:0] year_nx;
  logic [7:0] month_d;
  logic [7:0] year_d;
  logic [3:0] yr_t;
  logic [3:0] yr_u;
  logic [3:0] yn_t;
  logic [3:0] yn_u;

  assign count_ev = ENABLE & CARRY_in & ~SET_MODE;

  assign month_ok = (month >= 8'h01 && month <= 8'h09) ||
                    (month >= 8'h10 && month <= 8'h12);
  assign month_wrap = (month == 8'h12);
  assign year_wrap  = (YEAR == 8'h99);

  always_comb begin
    month_nx = 8'h01;
    if (month_ok && !month_wrap) begin
      if (month[3:0] == 4'h9) begin
        month_nx = 8'h10;
      end else begin
        month_nx = {month[7:4], 4'(month[3:0] + 4'd1)};
      end
    end
  end

  assign yr_t = YEAR[7:4];
  assign yr_u = YEAR[3:0];

  // Non-BCD nibbles are squashed to zero on the next increment.
  always_comb begin
    yn_u = 4'd0;
    yn_t = (yr_t > 4'd9) ? 4'd0 : yr_t;
    if (yr_u == 4'd9) begin
      yn_u = 4'd0;
      if (yr_t >= 4'd9) begin
        yn_t = 4'd0;
      end else begin
        yn_t = 4'(yr_t + 4'd1);
      end
    end else if (yr_u < 4'd9) begin
      yn_u = 4'(yr_u + 4'd1);
    end
  end

  assign year_nx = {yn_t, yn_u};

  always_comb begin
    month_d = month;
    year_d  = YEAR;
    if (SET_MODE) begin
      if (SET_INC && !SET_SEL) begin
        month_d = month_nx;
      end
      if (SET_INC && SET_SEL) begin
        year_d = year_nx;
      end
    end else if (count_ev) begin
      month_d = month_nx;
      if (month_wrap) begin
        year_d = year_nx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      month <= 8'h01;
      YEAR  <= 8'h00;
    end else begin
      month <= month_d;
      YEAR  <= year_d;
    end
  end

  // Divisible by 4 read straight off the BCD digits.
  always_comb begin
    if (!yr_t[0]) begin
      is_leap = (yr_u == 4'd0) || (yr_u == 4'd4) ||
                (yr_u == 4'd8);
    end else begin
      is_leap = (yr_u == 4'd2) || (yr_u == 4'd6);
    end
  end

  always_comb begin
    case (month)
      8'h02:   DAYS_IN_MONTH = is_leap ? 8'h29 : 8'h28;
      8'h04,
      8'h06,
      8'h09,
      8'h11:   DAYS_IN_MONTH = 8'h30;
      default: DAYS_IN_MONTH = 8'h31;
    endcase
  end

  assign CARRY_out   = count_ev & month_wrap & year_wrap;
  assign CENTURY_out = CENTURY;

endmodule

// File: tb/tb_cnt_month_year.sv
// Bench for cnt_month_year: vector table, directed sequences and
// random stimulus against a calendar model kept in plain integers.
module tb_cnt_month_year;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic       CARRY_in = 1'b0;
  logic       SET_MODE = 1'b0;
  logic       SET_SEL = 1'b0;
  logic       SET_INC = 1'b0;
  logic [7:0] month;
  logic [7:0] YEAR;
  logic [7:0] CENTURY_out;
  logic       is_leap;
  logic [7:0] DAYS_IN_MONTH;
  logic       CARRY_out;

  cnt_month_year #(.CENTURY(8'h20)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .CARRY_in(CARRY_in),
    .SET_MODE(SET_MODE),
    .SET_SEL(SET_SEL),
    .SET_INC(SET_INC),
    .month(month),
    .YEAR(YEAR),
    .CENTURY_out(CENTURY_out),
    .is_leap(is_leap),
    .DAYS_IN_MONTH(DAYS_IN_MONTH),
    .CARRY_out(CARRY_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       r, e, c, sm, sel, inc;
    logic       ecarry;
    logic [7:0] emonth, eyear;
    logic       eleap;
    logic [7:0] edim;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int m = 1;
  int y = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int days_of(input int mm, input int yy);
    if (mm == 2) return (yy % 4 == 0) ? 29 : 28;
    if (mm == 4 || mm == 6 || mm == 9 || mm == 11) return 30;
    return 31;
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (model %0d/%0d)",
               name, act, exp, m, y);
    end
  endtask

  task automatic check_state();
    chk("month", month, bcd(m));
    chk("year", YEAR, bcd(y));
    chk("is_leap", 8'(is_leap), 8'(y % 4 == 0));
    chk("days", DAYS_IN_MONTH, bcd(days_of(m, y)));
    chk("century", CENTURY_out, 8'h20);
  endtask

  task automatic cycle(input logic r, e, c, sm, sel, inc);
    logic ev;
    logic exp_c;
    int nm, ny;
    @(negedge CLK);
    RESET = r; ENABLE = e; CARRY_in = c;
    SET_MODE = sm; SET_SEL = sel; SET_INC = inc;
    ev = e & c & ~sm;
    exp_c = ev && m == 12 && y == 99;
    nm = m;
    ny = y;
    if (r) begin
      nm = 1; ny = 0;
    end else if (sm) begin
      if (inc && sel) ny = (y + 1) % 100;
      if (inc && !sel) nm = m % 12 + 1;
    end else if (ev) begin
      if (m == 12) begin
        nm = 1; ny = (y + 1) % 100;
      end else begin
        nm = m + 1;
      end
    end
    #1 chk("carry_out", 8'(CARRY_out), 8'(exp_c));
    @(posedge CLK);
    #1;
    m = nm;
    y = ny;
    check_state();
  endtask

  task automatic add(input logic r, e, c, sm, sel, inc, ec,
                     input logic [7:0] em, ey, input logic el,
                     input logic [7:0] ed);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.sm = sm; v.sel = sel; v.inc = inc;
    v.ecarry = ec; v.emonth = em; v.eyear = ey;
    v.eleap = el; v.edim = ed;
    vecs.push_back(v);
  endtask

  task automatic set_month(input int target);
    while (m != target) cycle(0, 0, 0, 1, 0, 1);
  endtask

  task automatic set_year(input int target);
    while (y != target) cycle(0, 0, 0, 1, 1, 1);
  endtask

  int leap_yes[4] = '{0, 4, 12, 96};
  int leap_no[3]  = '{1, 10, 98};

  initial begin
    // r e c sm sel inc | carry month year leap dim
    add(1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 1, 8'h31);
    add(1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 1, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h02, 8'h00, 1, 8'h29);
    add(0, 0, 1, 0, 0, 0, 0, 8'h02, 8'h00, 1, 8'h29);
    add(0, 1, 1, 1, 0, 0, 0, 8'h02, 8'h00, 1, 8'h29);
    add(0, 0, 0, 1, 0, 1, 0, 8'h03, 8'h00, 1, 8'h31);
    add(0, 0, 0, 1, 1, 1, 0, 8'h03, 8'h01, 0, 8'h31);
    add(0, 0, 0, 0, 1, 1, 0, 8'h03, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h04, 8'h01, 0, 8'h30);
    add(0, 1, 1, 0, 0, 0, 0, 8'h05, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h06, 8'h01, 0, 8'h30);
    add(0, 1, 1, 0, 0, 0, 0, 8'h07, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h08, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h09, 8'h01, 0, 8'h30);
    add(0, 1, 1, 0, 0, 0, 0, 8'h10, 8'h01, 0, 8'h31);
    add(0, 0, 1, 0, 0, 0, 0, 8'h10, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h11, 8'h01, 0, 8'h30);
    add(0, 1, 1, 0, 0, 0, 0, 8'h12, 8'h01, 0, 8'h31);
    add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 0, 8'h31);
    add(0, 0, 0, 1, 0, 1, 0, 8'h02, 8'h02, 0, 8'h28);
    add(1, 0, 0, 1, 0, 1, 0, 8'h01, 8'h00, 1, 8'h31);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].c,
            vecs[i].sm, vecs[i].sel, vecs[i].inc);
      chk($sformatf("vec%0d carry", i), 8'(CARRY_out), 8'(0));
      chk($sformatf("vec%0d month", i), month, vecs[i].emonth);
      chk($sformatf("vec%0d year", i), YEAR, vecs[i].eyear);
      chk($sformatf("vec%0d leap", i), 8'(is_leap), 8'(vecs[i].eleap));
      chk($sformatf("vec%0d dim", i), DAYS_IN_MONTH, vecs[i].edim);
    end

    // 12/23 + carry -> 01/24, then February of a leap year
    cycle(1, 0, 0, 0, 0, 0);
    set_month(12);
    set_year(23);
    cycle(0, 1, 1, 0, 0, 0);
    chk("roll month", month, 8'h01);
    chk("roll year", YEAR, 8'h24);
    chk("roll leap", 8'(is_leap), 8'h01);
    set_month(2);
    chk("feb24 dim", DAYS_IN_MONTH, 8'h29);

    // 12/99 + carry -> century carry for one cycle, then 01/00
    set_month(12);
    set_year(99);
    @(negedge CLK);
    SET_MODE = 0; SET_INC = 0; ENABLE = 1; CARRY_in = 1;
    #1 chk("century carry", 8'(CARRY_out), 8'h01);
    @(posedge CLK);
    #1;
    m = 1; y = 0;
    chk("wrap month", month, 8'h01);
    chk("wrap year", YEAR, 8'h00);
    cycle(0, 1, 1, 0, 0, 0);
    chk("carry dropped", 8'(CARRY_out), 8'h00);

    // Set-mode year wrap never raises the carry
    set_month(12);
    set_year(99);
    cycle(0, 1, 1, 1, 1, 1);
    chk("set wrap year", YEAR, 8'h00);
    chk("set wrap month", month, 8'h12);

    // Set mode month adjust with carries present
    set_year(37);
    set_month(11);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0, 1);
    chk("set month 02", month, 8'h02);
    chk("set year hold", YEAR, 8'h37);

    // Leap sweep at February
    cycle(1, 0, 0, 0, 0, 0);
    set_month(2);
    foreach (leap_yes[i]) begin
      set_year(leap_yes[i]);
      chk("leap yes", 8'(is_leap), 8'h01);
      chk("leap yes dim", DAYS_IN_MONTH, 8'h29);
    end
    foreach (leap_no[i]) begin
      set_year(leap_no[i]);
      chk("leap no", 8'(is_leap), 8'h00);
      chk("leap no dim", DAYS_IN_MONTH, 8'h28);
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 999) == 0,
            1'($urandom_range(0, 3) != 0),
            1'($urandom),
            $urandom_range(0, 3) == 0,
            1'($urandom),
            1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
